fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch and PC sequencer for the LEGv8 single-cycle core; the producing end of the decode interface.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents the opcode field Inst[31:21] and condition field Inst[3:0] to the control unit.
- Consumes the control unit's PCSrc selection to compute the next PC when the execute stage signals completion.

Parameters:
ADDR_W, 64, PC and address width in bits
RESET_PC, 0, PC value loaded on reset
TIMEOUT_CYC, 16, ack watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pcsrc  in  2  next-PC select from control unit: 0 = PC+4, 1 = PC+(imm<<2), 2 = reg_target, 3 = PC+4
branch_imm  in  ADDR_W  sign-extended word offset from the SEU
reg_target  in  ADDR_W  register value for BR
exec_done  in  1  one-cycle pulse: current instruction retired, pcsrc/branch_imm/reg_target valid
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, equal to pc
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction word
inst_valid  out  1  inst/opcode/cond valid for decode
inst  out  32  latched instruction
opcode  out  11  inst[31:21] to control unit
cond  out  4  inst[3:0] to control unit (B.cond)
pc  out  ADDR_W  current PC
pc_plus4  out  ADDR_W  pc+4, used as BL link value
fetch_err  out  1  sticky timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset values: state IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_err=0.
- Outputs are direct functions of registers: opcode, cond, imem_addr, pc_plus4.
- FSM states: IDLE, FETCH, DECODE.
  - IDLE: go to FETCH on the first edge after reset release.
  - FETCH: imem_req=1, imem_addr=pc held stable. When imem_ack=1 at an edge: latch inst=imem_rdata, set inst_valid=1, go to DECODE.
  - DECODE: imem_req=0, inst_valid=1. When exec_done=1 at an edge: update pc, clear inst_valid, go to FETCH.
- Next PC, evaluated in DECODE on exec_done, all arithmetic modulo 2^ADDR_W (wrap silently):
  - pcsrc 0: pc+4
  - pcsrc 1: pc+(branch_imm<<2)
  - pcsrc 2: reg_target
  - pcsrc 3: pc+4
- Latency:
  - Ack at edge N makes inst_valid=1 after edge N.
  - exec_done at edge M makes the new pc and imem_req=1 visible after edge M.
  - Minimum 2 cycles per instruction with zero-wait memory.
- Boundary conditions:
  - imem_ack outside FETCH: ignored.
  - exec_done outside DECODE: ignored.
  - exec_done and imem_ack both high in DECODE: only exec_done acts.
  - Reset asserted mid-fetch: immediate return to reset values; a late ack after release is ignored until FETCH is re-entered.
  - reg_target is used as given; no alignment check.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter increments each cycle in FETCH without ack.
  - When it reaches TIMEOUT_CYC, fetch_err sets (sticky until reset), the counter clears, and the request continues at the same pc.
  - The counter clears on ack and on leaving FETCH.
- Undefined: no counter; fetch_err constant 0.

Test Plan:
- Reset release, zero-wait memory: ack every FETCH cycle with rdata=0x8B020020, pcsrc=0, exec_done each DECODE cycle -> imem_addr sequence 0,4,8,12; opcode=0x458.
- Branch: pc=0x10, inst 0x14000003, pcsrc=1, branch_imm=3 -> next imem_addr=0x1C; branch_imm=-4 (all ones except low bits) -> next imem_addr=0x00.
- BR: pc=0x40, pcsrc=2, reg_target=0x200 -> next imem_addr=0x200; pc_plus4 was 0x44 during DECODE.
- Wait states: ack delayed 5 cycles -> imem_req high and imem_addr stable for 6 cycles; exec_done pulses during FETCH produce no pc change.
- Reset mid-FETCH at pc=0x80, ack arriving 1 cycle after release -> pc=RESET_PC, inst_valid stays 0, first accepted fetch is at RESET_PC.
- FETCH_TIMEOUT_EN defined, TIMEOUT_CYC=16, no ack for 20 cycles -> fetch_err=1 from cycle 16, imem_req still 1; later ack -> normal DECODE, fetch_err remains 1.

Source files
------------

// File: rtl/fetch_sequencer.sv
// LEGv8 PC holder and instruction fetcher feeding decode; optional ack watchdog under FETCH_TIMEOUT_EN.
// Latency: an ack at an edge shows inst_valid after that edge; exec_done at an edge shows the new pc and imem_req after it.
// Backpressure: the request and address stay stable until imem_ack; the fetched word is held until exec_done.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pcsrc,
  input  logic [ADDR_W-1:0] branch_imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              exec_done,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [10:0]       opcode,
  output logic [3:0]        cond,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] next_pc;

  // pcsrc 3 is treated as sequential, same as 0.
  always_comb begin
    case (pcsrc)
      2'd1:    next_pc = pc_q + (branch_imm << 2);
      2'd2:    next_pc = reg_target;
      default: next_pc = pc_q + FOUR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // An ack arriving here is not relatched; only retirement moves the PC.
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign inst_valid = (state_q == DECODE);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + FOUR;
  assign inst       = inst_q;
  assign opcode     = inst_q[31:21];
  assign cond       = inst_q[3:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // Watchdog only flags; the request keeps running at the same pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (state_q == FETCH && !imem_ack) begin
      if (wait_cnt_q == CNT_LAST) begin
        wait_cnt_q <= '0;
        err_q      <= 1'b1;
      end else begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized run against a reference model.
module tb_fetch_sequencer;
  localparam int unsigned AW = 64;
  localparam int unsigned TO = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    pcsrc = '0;
  logic [AW-1:0] branch_imm = '0;
  logic [AW-1:0] reg_target = '0;
  logic          exec_done = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [10:0]   opcode;
  logic [3:0]    cond;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus4;
  logic          fetch_err;

  int checks = 0;
  int errors = 0;

  // Reference model: what the sequencer should be holding, by the rules.
  logic [AW-1:0] m_pc;
  bit            m_idle;
  bit            m_have;
  logic [31:0]   m_inst;
  int            m_wait;
  bit            m_err;

  fetch_sequencer #(.ADDR_W(AW), .RESET_PC('0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc), .branch_imm(branch_imm),
    .reg_target(reg_target), .exec_done(exec_done), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .opcode(opcode), .cond(cond),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0; m_idle = 1'b1; m_have = 1'b0; m_inst = '0; m_wait = 0; m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, pass the edge, advance the model; returns at edge+1.
  task automatic cycle(input bit ack, input logic [31:0] rd, input bit ed,
                       input logic [1:0] ps, input logic [AW-1:0] imm, input logic [AW-1:0] tgt);
    imem_ack = ack; imem_rdata = rd; exec_done = ed; pcsrc = ps; branch_imm = imm; reg_target = tgt;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (m_idle) m_idle = 1'b0;
      else if (!m_have) begin
        if (ack) begin m_have = 1'b1; m_inst = rd; m_wait = 0; end
        else if (TO_EN) begin
          m_wait++;
          if (m_wait == TO) begin m_err = 1'b1; m_wait = 0; end
        end
      end else if (ed) begin
        if (ps == 2'd1) m_pc = m_pc + imm * 4;
        else if (ps == 2'd2) m_pc = tgt;
        else m_pc = m_pc + 4;
        m_have = 1'b0;
      end
    end
  endtask

  task automatic run_inst(input logic [31:0] rd, input int dly, input logic [1:0] ps,
                          input logic [AW-1:0] imm, input logic [AW-1:0] tgt);
    repeat (dly) cycle(1'b0, rd, 1'b0, 2'd0, '0, '0);
    cycle(1'b1, rd, 1'b0, 2'd0, '0, '0);
    cycle(1'b0, rd, 1'b1, ps, imm, tgt);
  endtask

  task automatic goto_pc(input logic [AW-1:0] a);
    run_inst(32'hD61F0000, 0, 2'd2, '0, a);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    imem_ack = 1'b1; exec_done = 1'b1; imem_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", fetch_err); end
    imem_ack = 1'b0; exec_done = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [AW-1:0] exp_addr [4] = '{64'd0, 64'd4, 64'd8, 64'd12};
    logic [AW-1:0] seen [$];
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 32'h8B020020, 1'b1, 2'd0, '0, '0);
      if (imem_req === 1'b1) seen.push_back(imem_addr);
      if (inst_valid === 1'b1) begin
        checks++;
        if (opcode !== 11'h458 || cond !== 4'h0) begin
          errors++; $display("FAIL zw_opcode got %h/%h want 458/0", opcode, cond);
        end
      end
    end
    checks++; if (seen.size() != 4) begin errors++; $display("FAIL zw_count got %0d want 4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp_addr[i]) begin errors++; $display("FAIL zw_addr%0d got %h want %h", i, seen[i], exp_addr[i]); end
    end
  endtask

  task automatic test_branch();
    goto_pc(64'h10);
    checks++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL br_setup got %h want 10", imem_addr); end
    cycle(1'b1, 32'h14000003, 1'b0, 2'd0, '0, '0);
    checks++; if (opcode !== 11'h0A0 || cond !== 4'h3) begin errors++; $display("FAIL b_fields got %h/%h want 0a0/3", opcode, cond); end
    cycle(1'b0, 32'h0, 1'b1, 2'd1, 64'd3, '0);
    checks++; if (imem_addr !== 64'h1C || imem_req !== 1'b1) begin errors++; $display("FAIL b_fwd got %h/%b want 1c/1", imem_addr, imem_req); end
    goto_pc(64'h10);
    run_inst(32'h17FFFFFC, 0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL b_back got %h want 0", imem_addr); end
  endtask

  task automatic test_br();
    goto_pc(64'h40);
    cycle(1'b1, 32'hD61F0000, 1'b0, 2'd0, '0, '0);
    checks++; if (pc_plus4 !== 64'h44 || inst_valid !== 1'b1) begin errors++; $display("FAIL br_link got %h/%b want 44/1", pc_plus4, inst_valid); end
    checks++; if (inst !== 32'hD61F0000) begin errors++; $display("FAIL br_inst got %h want d61f0000", inst); end
    cycle(1'b0, 32'h0, 1'b1, 2'd2, '0, 64'h200);
    checks++; if (imem_addr !== 64'h200 || inst_valid !== 1'b0) begin errors++; $display("FAIL br_tgt got %h/%b want 200/0", imem_addr, inst_valid); end
    run_inst(32'h0, 0, 2'd3, 64'd99, 64'h777);
    checks++; if (imem_addr !== 64'h204) begin errors++; $display("FAIL pcsrc3 got %h want 204", imem_addr); end
    run_inst(32'h0, 0, 2'd2, '0, 64'h333);
    checks++; if (imem_addr !== 64'h333) begin errors++; $display("FAIL br_unaligned got %h want 333", imem_addr); end
  endtask

  task automatic test_wait_states();
    int hi = 0;
    goto_pc(64'h300);
    if (imem_req === 1'b1 && imem_addr === 64'h300) hi++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 2'd2, '0, 64'h999);
      if (imem_req === 1'b1 && imem_addr === 64'h300) hi++;
    end
    checks++; if (hi != 6) begin errors++; $display("FAIL ws_hold got %0d want 6", hi); end
    cycle(1'b1, 32'hAAAA5555, 1'b0, 2'd0, '0, '0);
    checks++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL ws_accept got %b/%b want 1/0", inst_valid, imem_req); end
    cycle(1'b1, 32'h12345678, 1'b0, 2'd0, '0, '0);
    checks++; if (inst !== 32'hAAAA5555 || inst_valid !== 1'b1) begin errors++; $display("FAIL ws_late_ack got %h/%b want aaaa5555/1", inst, inst_valid); end
    cycle(1'b1, 32'h12345678, 1'b1, 2'd0, '0, '0);
    checks++; if (imem_addr !== 64'h304 || inst_valid !== 1'b0 || inst !== 32'hAAAA5555) begin
      errors++; $display("FAIL ws_both got %h/%b/%h want 304/0/aaaa5555", imem_addr, inst_valid, inst);
    end
  endtask

  task automatic test_reset_mid_fetch();
    goto_pc(64'h80);
    cycle(1'b0, 32'h0, 1'b0, 2'd0, '0, '0);
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 64'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmf_async got %h/%b want 0/0", pc, imem_req); end
    model_reset();
    cycle(1'b0, 32'h0, 1'b0, 2'd0, '0, '0);
    rst_n = 1'b1;
    cycle(1'b1, 32'hCAFE0001, 1'b0, 2'd0, '0, '0);
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL rmf_late_ack got %b/%b/%h want 0/1/0", inst_valid, imem_req, imem_addr);
    end
    cycle(1'b1, 32'h8B020020, 1'b0, 2'd0, '0, '0);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h8B020020 || pc !== 64'h0) begin
      errors++; $display("FAIL rmf_first got %b/%h/%h want 1/8b020020/0", inst_valid, inst, pc);
    end
  endtask

  task automatic test_random();
    bit ack, ed;
    logic [1:0] ps;
    logic [31:0] r;
    logic [AW-1:0] imm, tgt;
    for (int n = 0; n < 400; n++) begin
      ack = ($urandom_range(0, 3) != 0);
      ed  = ($urandom_range(0, 1) != 0);
      ps  = 2'($urandom_range(0, 3));
      r   = $urandom;
      imm = {{32{r[31]}}, r};
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0; model_reset();
        cycle(ack, $urandom, ed, ps, imm, tgt);
        rst_n = 1'b1;
      end else begin
        cycle(ack, $urandom, ed, ps, imm, tgt);
      end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr n=%0d got %h want %h", n, imem_addr, m_pc); end
      checks++; if (imem_req !== (!m_have && !m_idle)) begin errors++; $display("FAIL rnd_req n=%0d got %b want %b", n, imem_req, !m_have && !m_idle); end
      checks++; if (inst_valid !== m_have) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, inst_valid, m_have); end
      checks++; if (pc_plus4 !== m_pc + 64'd4) begin errors++; $display("FAIL rnd_plus4 n=%0d got %h want %h", n, pc_plus4, m_pc + 64'd4); end
      checks++; if (fetch_err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b want %b", n, fetch_err, m_err); end
      if (m_have) begin
        checks++;
        if (inst !== m_inst || opcode !== m_inst[31:21] || cond !== m_inst[3:0]) begin
          errors++; $display("FAIL rnd_inst n=%0d got %h/%h/%h want %h", n, inst, opcode, cond, m_inst);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit exp_err;
    rst_n = 1'b0; model_reset();
    cycle(1'b0, 32'h0, 1'b0, 2'd0, '0, '0);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 2'd2, '0, 64'h55);
      exp_err = TO_EN && (k >= TO);
      checks++; if (fetch_err !== exp_err || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
        errors++; $display("FAIL to_k%0d got %b/%b/%h want %b/1/0", k, fetch_err, imem_req, imem_addr, exp_err);
      end
    end
    cycle(1'b1, 32'h8B020020, 1'b0, 2'd0, '0, '0);
    checks++; if (inst_valid !== 1'b1 || fetch_err !== TO_EN) begin errors++; $display("FAIL to_ack got %b/%b want 1/%b", inst_valid, fetch_err, TO_EN); end
    cycle(1'b0, 32'h0, 1'b1, 2'd0, '0, '0);
    checks++; if (imem_addr !== 64'h4 || fetch_err !== TO_EN) begin errors++; $display("FAIL to_next got %h/%b want 4/%b", imem_addr, fetch_err, TO_EN); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_branch();
    test_br();
    test_wait_states();
    test_reset_mid_fetch();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
